// File: rtl/bt_uart_pkg.sv
// Shared types for the Bluetooth UART receiver.
// FSM state enum, data-bit count and bit-index width.
package bt_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int IDX_W     = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

endpackage

// File: rtl/bt_rx_fifo.sv
// Synchronous receive FIFO: push/pop, count, valid, overrun pulse.
// Ports: clk_i, rst_i (async high), push_i, data_i, pop_i, data_o, valid_o, count_o, overrun_o.
module bt_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overrun_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             ovr_q;
  logic             empty, full;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  // A pop frees the slot in the same edge, so a full FIFO still accepts.
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | pop_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovr_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
      ovr_q <= push_i & full & ~pop_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign data_o    = empty ? '0 : mem_q[rd_q];
  assign valid_o   = ~empty;
  assign count_o   = cnt_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/bt_uart_rx.sv
// Bluetooth UART receiver: 8N1 (8E1 with BT_UART_PARITY_EN), FIFO, RTS flow control.
// Ports: clock, reset, rx_in, rts_n, rd_en, rd_data, rd_valid, fifo_count, *_err pulses.
module bt_uart_rx
  import bt_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8,
  parameter int RTS_THRESH   = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx_in,
  output logic                          rts_n,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun_err,
  output logic                          parity_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;

  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic                 rx, fall, tick;
  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 push, ferr_d, ferr_q, rts_q;

  assign rx   = rx_s2_q;
  assign fall = rx_prev_q & ~rx_s2_q;
  assign tick = (cnt_q == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx_in;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (fall) state_d = START;
      START:  if (tick) state_d = rx ? IDLE : DATA;
      DATA:
        if (tick && idx_q == IDX_W'(DATA_BITS - 1))
`ifdef BT_UART_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef BT_UART_PARITY_EN
  logic par_q, par_d, par_bad, perr_d, perr_q;
  // Even parity: data plus parity bit must XOR to zero.
  assign par_bad = ^{sh_q, par_q};
`endif

  // Bit timer, index and shift register.
  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    sh_d  = sh_q;
`ifdef BT_UART_PARITY_EN
    par_d = par_q;
`endif
    if (state_q == IDLE) begin
      // Half a bit, so later samples land mid-bit.
      if (fall) cnt_d = CW'(CLKS_PER_BIT / 2 - 1);
    end else if (tick) begin
      cnt_d = CW'(CLKS_PER_BIT - 1);
      if (state_q == START) idx_d = '0;
      if (state_q == DATA) begin
        sh_d  = {rx, sh_q[DATA_BITS-1:1]};
        idx_d = idx_q + IDX_W'(1);
      end
`ifdef BT_UART_PARITY_EN
      if (state_q == PARITY) par_d = rx;
`endif
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Stop-bit decision: push or report.
  always_comb begin
    push   = 1'b0;
    ferr_d = 1'b0;
`ifdef BT_UART_PARITY_EN
    perr_d = 1'b0;
`endif
    if (state_q == STOP && tick) begin
      if (!rx) ferr_d = 1'b1;
`ifdef BT_UART_PARITY_EN
      else if (par_bad) perr_d = 1'b1;
`endif
      else push = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      sh_q   <= '0;
      ferr_q <= 1'b0;
      rts_q  <= 1'b1;
`ifdef BT_UART_PARITY_EN
      par_q  <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      sh_q   <= sh_d;
      ferr_q <= ferr_d;
      rts_q  <= (fifo_count >= NW'(RTS_THRESH));
`ifdef BT_UART_PARITY_EN
      par_q  <= par_d;
      perr_q <= perr_d;
`endif
    end
  end

  bt_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i     (clock),
    .rst_i     (reset),
    .push_i    (push),
    .data_i    (sh_q),
    .pop_i     (rd_en),
    .data_o    (rd_data),
    .valid_o   (rd_valid),
    .count_o   (fifo_count),
    .overrun_o (overrun_err)
  );

  assign rts_n     = rts_q;
  assign frame_err = ferr_q;
`ifdef BT_UART_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_bt_uart_rx.sv
// Self-checking bench for bt_uart_rx (8N1 build).
// Random bytes against a queue model of the receive FIFO.
module tb_bt_uart_rx;

  localparam int CPB = 16;
  localparam int DEP = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic       rd_en = 1'b0;
  logic       rts_n, rd_valid;
  logic [7:0] rd_data;
  logic [3:0] fifo_count;
  logic       frame_err, overrun_err, parity_err;

  int total = 0;
  int bad   = 0;
  int fe_n  = 0;
  int ov_n  = 0;
  int pe_n  = 0;
  logic [7:0] exp_q[$];

  bt_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEP),
    .RTS_THRESH   (6)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .rx_in       (rx_in),
    .rts_n       (rts_n),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_count  (fifo_count),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    fe_n += int'(frame_err);
    ov_n += int'(overrun_err);
    pe_n += int'(parity_err);
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_head(input logic [7:0] b);
    rx_in = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      hold(CPB);
    end
  endtask

  // Full frame; the model accepts a good byte unless the FIFO is full.
  task automatic send_frame(input logic [7:0] b, input logic stopv);
    send_head(b);
    rx_in = stopv;
    hold(CPB);
    rx_in = 1'b1;
    hold(4);
    if (stopv && exp_q.size() < DEP) exp_q.push_back(b);
  endtask

  task automatic pop_check(input string nm);
    @(negedge clock);
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s model empty, rd_valid=%b", nm, rd_valid);
    end else if (rd_valid !== 1'b1 || rd_data !== exp_q[0]) begin
      bad++;
      $display("FAIL %s valid=%b data=%h want %h", nm, rd_valid, rd_data,
               exp_q[0]);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    rd_en = 1'b1;
    @(posedge clock);
    #1;
    rd_en = 1'b0;
  endtask

  task automatic check_count(input string nm);
    @(negedge clock);
    total++;
    if (fifo_count !== 4'(exp_q.size()) ||
        rd_valid !== (exp_q.size() != 0)) begin
      bad++;
      $display("FAIL %s count=%0d valid=%b want count=%0d", nm,
               fifo_count, rd_valid, exp_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    total++;
    if ({rts_n, rd_valid, rd_data, fifo_count, frame_err, overrun_err,
         parity_err} !== {1'b1, 1'b0, 8'h00, 4'd0, 3'b000}) begin
      bad++;
      $display("FAIL reset_vals rts=%b v=%b d=%h c=%0d want 1 0 00 0", rts_n,
               rd_valid, rd_data, fifo_count);
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    total++;
    if (rts_n !== 1'b0) begin
      bad++;
      $display("FAIL rts_after_reset got=%b want=0", rts_n);
    end
  endtask

  task automatic test_basic();
    int f0 = fe_n;
    int o0 = ov_n;
    int p0 = pe_n;
    send_frame(8'hA5, 1'b1);
    check_count("basic_count");
    pop_check("basic_data");
    check_count("basic_empty");
    total++;
    if (fe_n != f0 || ov_n != o0 || pe_n != p0) begin
      bad++;
      $display("FAIL basic_errs fe=%0d ov=%0d pe=%0d want 0 0 0",
               fe_n - f0, ov_n - o0, pe_n - p0);
    end
  endtask

  task automatic test_glitch();
    int f0 = fe_n;
    for (int w = 1; w <= 6; w++) begin
      rx_in = 1'b0;
      hold(w);
      rx_in = 1'b1;
      hold(30);
    end
    check_count("glitch_count");
    total++;
    if (fe_n != f0) begin
      bad++;
      $display("FAIL glitch_err got=%0d want=0", fe_n - f0);
    end
    send_frame(8'($urandom_range(0, 255)), 1'b1);
    pop_check("glitch_recover");
  endtask

  task automatic test_frame_err();
    int f0 = fe_n;
    send_frame(8'h3C, 1'b0);
    check_count("ferr_count");
    total++;
    if (fe_n - f0 != 1) begin
      bad++;
      $display("FAIL ferr_pulses got=%0d want=1", fe_n - f0);
    end
    f0 = fe_n;
    rx_in = 1'b0;
    hold(30 * CPB);
    rx_in = 1'b1;
    hold(20);
    total++;
    if (fe_n - f0 != 1) begin
      bad++;
      $display("FAIL break_pulses got=%0d want=1", fe_n - f0);
    end
    check_count("break_count");
    send_frame(8'h81, 1'b1);
    pop_check("after_break");
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1);
      check_count("rand_count");
      if ($urandom_range(0, 2) == 0) pop_check("rand_pop");
    end
    while (exp_q.size() != 0) pop_check("rand_drain");
    check_count("rand_empty");
  endtask

  task automatic test_rts();
    bit seen = 0;
    for (int k = 0; k < 5; k++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    @(negedge clock);
    total++;
    if (rts_n !== 1'b0) begin
      bad++;
      $display("FAIL rts_at5 got=%b want=0", rts_n);
    end
    begin
      logic [7:0] b6 = 8'($urandom_range(0, 255));
      send_head(b6);
      rx_in = 1'b1;
      exp_q.push_back(b6);
    end
    for (int t = 0; t < 40 && !seen; t++) begin
      @(negedge clock);
      if (fifo_count == 4'd6) seen = 1;
    end
    total++;
    if (!seen || rts_n !== 1'b0) begin
      bad++;
      $display("FAIL rts_edge seen=%b rts=%b want 1 0", seen, rts_n);
    end
    @(negedge clock);
    total++;
    if (rts_n !== 1'b1) begin
      bad++;
      $display("FAIL rts_high got=%b want=1", rts_n);
    end
    hold(20);
    pop_check("rts_pop");
    @(negedge clock);
    total++;
    if (rts_n !== 1'b1 || fifo_count !== 4'd5) begin
      bad++;
      $display("FAIL rts_lag rts=%b c=%0d want 1 5", rts_n, fifo_count);
    end
    @(negedge clock);
    total++;
    if (rts_n !== 1'b0) begin
      bad++;
      $display("FAIL rts_low got=%b want=0", rts_n);
    end
    while (exp_q.size() != 0) pop_check("rts_drain");
  endtask

  task automatic test_overrun();
    int o0 = ov_n;
    logic [7:0] b9;
    for (int k = 0; k < 9; k++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    check_count("ovr_count");
    total++;
    if (ov_n - o0 != 1) begin
      bad++;
      $display("FAIL ovr_pulses got=%0d want=1", ov_n - o0);
    end
    while (exp_q.size() != 0) pop_check("ovr_order");
    for (int k = 0; k < 8; k++) send_frame(8'($urandom_range(0, 255)), 1'b1);
    o0 = ov_n;
    b9 = 8'($urandom_range(0, 255));
    send_head(b9);
    rx_in = 1'b1;
    // Start edge at +0; mid-stop push lands on edge +155.
    hold(10);
    total++;
    if (rd_data !== exp_q[0]) begin
      bad++;
      $display("FAIL ovr_head got=%h want=%h", rd_data, exp_q[0]);
    end
    rd_en = 1'b1;
    @(posedge clock);
    #1;
    rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(b9);
    hold(10);
    check_count("pushpop_count");
    total++;
    if (ov_n != o0) begin
      bad++;
      $display("FAIL pushpop_ovr got=%0d want=0", ov_n - o0);
    end
    while (exp_q.size() != 0) pop_check("pushpop_order");
  endtask

  task automatic test_reset_mid();
    int f0;
    send_frame(8'($urandom_range(0, 255)), 1'b1);
    rx_in = 1'b0;
    hold(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_in = i[0];
      hold(CPB);
    end
    reset = 1'b1;
    rx_in = 1'b1;
    exp_q.delete();
    @(negedge clock);
    total++;
    if ({rts_n, rd_valid, rd_data, fifo_count} !==
        {1'b1, 1'b0, 8'h00, 4'd0}) begin
      bad++;
      $display("FAIL midrst_vals rts=%b v=%b d=%h c=%0d", rts_n, rd_valid,
               rd_data, fifo_count);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    f0 = fe_n;
    hold(40);
    total++;
    if (rts_n !== 1'b0 || rd_valid !== 1'b0 || fe_n != f0) begin
      bad++;
      $display("FAIL midrst_after rts=%b v=%b fe=%0d", rts_n, rd_valid,
               fe_n - f0);
    end
    send_frame(8'h0F, 1'b1);
    check_count("midrst_count");
    pop_check("midrst_data");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_random();
    test_rts();
    test_overrun();
    test_reset_mid();
    total++;
    if (pe_n != 0) begin
      bad++;
      $display("FAIL parity_pulses got=%0d want=0", pe_n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
